// File: rtl/pipe_fetch_ctl.sv
// pipe_fetch_ctl
// Instruction-fetch stage plus IF/ID pipeline register of the five-stage CPU.
// Holds the PC and drives the instruction-memory address. Picks the next PC
// from the decode-stage controls. Squashes the slot behind a control transfer,
// holds on a load-use interlock, and inserts NOPs while memory is not ready.
// Keeps two saturating event counters.
//
// Ports:
//   clock, reset            - rising-edge clock; async active-high reset
//   wpcir                   - PC/IR write enable (0 = stall, everything holds)
//   pcsource[1:0]           - next-PC select: pc+4 / bpc / rpc / jpc
//   bubble                  - squash the slot being fetched this cycle
//   bpc, rpc, jpc           - branch / register / jump targets
//   imem_addr               - fetch address (== pc)
//   imem_rdata, imem_rdy    - combinational instruction read and its ready flag
//   pc                      - current PC register
//   dinst, dpc4, dvalid     - IF/ID instruction, pc+4 copy, real-instruction flag
//   squash_cnt, wait_cnt    - saturating counts of squashed slots / memory waits

module pipe_fetch_ctl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wpcir,
  input  logic [1:0]       pcsource,
  input  logic             bubble,
  input  logic [31:0]      bpc,
  input  logic [31:0]      rpc,
  input  logic [31:0]      jpc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_rdy,
  output logic [31:0]      pc,
  output logic [31:0]      dinst,
  output logic [31:0]      dpc4,
  output logic             dvalid,
  output logic [CNT_W-1:0] squash_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  // sll $0,$0,0 -- decode treats an all-zero word as a harmless no-op
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] pc4;
  logic [31:0] npc;

  // wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0
  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    npc = pc4;
    case (pcsource)
      2'b00:   npc = pc4;
      2'b01:   npc = bpc;
      2'b10:   npc = rpc;
      2'b11:   npc = jpc;
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      dinst      <= NOP;
      dpc4       <= 32'd0;
      dvalid     <= 1'b0;
      squash_cnt <= '0;
      wait_cnt   <= '0;
    end else if (!wpcir) begin
      // interlock stall: every register holds, other controls ignored
    end else if (bubble) begin
      // slot is discarded whether or not memory answered, so imem_rdy is moot
      pc     <= npc;
      dinst  <= NOP;
      dpc4   <= pc4;
      dvalid <= 1'b0;
      if (squash_cnt != '1)
        squash_cnt <= squash_cnt + CNT_W'(1);
    end else if (!imem_rdy) begin
      // pc holds so the same address is re-presented next cycle
      dinst  <= NOP;
      dpc4   <= pc4;
      dvalid <= 1'b0;
      if (wait_cnt != '1)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      pc     <= npc;
      dinst  <= imem_rdata;
      dpc4   <= pc4;
      dvalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_ctl.sv
module tb_pipe_fetch_ctl;

  logic        clock;
  logic        reset;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic        bubble;
  logic [31:0] bpc, rpc, jpc;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_rdy;
  logic [31:0] pc, dinst, dpc4;
  logic        dvalid;
  logic [15:0] squash_cnt, wait_cnt;

  // second instance with 2-bit counters for saturation checks
  logic        s_reset;
  logic        s_bubble;
  logic [31:0] s_imem_addr, s_imem_rdata;
  logic [31:0] s_pc, s_dinst, s_dpc4;
  logic        s_dvalid;
  logic [1:0]  s_squash_cnt, s_wait_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_fetch_ctl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
    .bubble(bubble), .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rdy(imem_rdy),
    .pc(pc), .dinst(dinst), .dpc4(dpc4), .dvalid(dvalid),
    .squash_cnt(squash_cnt), .wait_cnt(wait_cnt)
  );

  pipe_fetch_ctl #(.RESET_PC(32'h0000_1000), .CNT_W(2)) dut_s (
    .clock(clock), .reset(s_reset), .wpcir(1'b1), .pcsource(2'b00),
    .bubble(s_bubble), .bpc(32'd0), .rpc(32'd0), .jpc(32'd0),
    .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata), .imem_rdy(1'b1),
    .pc(s_pc), .dinst(s_dinst), .dpc4(s_dpc4), .dvalid(s_dvalid),
    .squash_cnt(s_squash_cnt), .wait_cnt(s_wait_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_0005;
      32'h0000_0004: mem_word = 32'h2109_0001;
      default:       mem_word = {8'hA5, a[23:0]};
    endcase
  endfunction

  always_comb imem_rdata   = mem_word(imem_addr);
  always_comb s_imem_rdata = mem_word(s_imem_addr);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; s_reset = 1'b1;
    wpcir = 1'b1; pcsource = 2'b00; bubble = 1'b0; s_bubble = 1'b0;
    bpc = 32'd0; rpc = 32'd0; jpc = 32'd0; imem_rdy = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_dinst", dinst, 32'h0);
    check_val("rst_dvalid", {31'd0, dvalid}, 32'd0);
    check_val("rst_sq", {16'd0, squash_cnt}, 32'd0);
    check_val("s_rst_pc", s_pc, 32'h1000);
    reset = 1'b0;
    #1;
    check_val("rel_addr", imem_addr, 32'h0);

    // two sequential fetches
    tick();
    check_val("e1_dinst", dinst, 32'h2008_0005);
    check_val("e1_dpc4", dpc4, 32'h4);
    check_val("e1_dvalid", {31'd0, dvalid}, 32'd1);
    check_val("e1_pc", pc, 32'h4);
    tick();
    check_val("e2_dinst", dinst, 32'h2109_0001);
    check_val("e2_pc", pc, 32'h8);

    // jump to 0x40
    bubble = 1'b1; pcsource = 2'b11; jpc = 32'h40;
    tick();
    check_val("j_pc", pc, 32'h40);
    check_val("j_dinst", dinst, 32'h0);
    check_val("j_dpc4", dpc4, 32'hC);
    check_val("j_sq", {16'd0, squash_cnt}, 32'd1);

    // taken branch 0x40 -> 0x100
    pcsource = 2'b01; bpc = 32'h100;
    tick();
    check_val("br_pc", pc, 32'h100);
    check_val("br_dinst", dinst, 32'h0);
    check_val("br_dvalid", {31'd0, dvalid}, 32'd0);
    check_val("br_sq", {16'd0, squash_cnt}, 32'd2);
    bubble = 1'b0; pcsource = 2'b00;
    tick();
    check_val("br_tgt_dinst", dinst, 32'hA500_0100);
    check_val("br_tgt_pc", pc, 32'h104);

    // back to 0x40, then not-taken bne
    bubble = 1'b1; pcsource = 2'b11; jpc = 32'h40;
    tick();
    check_val("j2_pc", pc, 32'h40);
    pcsource = 2'b00;
    tick();
    check_val("nt_pc", pc, 32'h44);
    check_val("nt_dinst", dinst, 32'h0);
    check_val("nt_sq", {16'd0, squash_cnt}, 32'd4);
    bubble = 1'b0;
    tick();
    check_val("f44_dinst", dinst, 32'hA500_0044);
    check_val("f44_pc", pc, 32'h48);

    // jr held by a 2-cycle interlock; imem_rdy=0 must be ignored too
    wpcir = 1'b0; bubble = 1'b1; pcsource = 2'b10; rpc = 32'h200; imem_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("st_pc", pc, 32'h48);
      check_val("st_dinst", dinst, 32'hA500_0044);
      check_val("st_sq", {16'd0, squash_cnt}, 32'd4);
      check_val("st_wait", {16'd0, wait_cnt}, 32'd0);
    end
    wpcir = 1'b1;
    tick();
    check_val("jr_pc", pc, 32'h200);
    check_val("jr_dinst", dinst, 32'h0);
    check_val("jr_sq", {16'd0, squash_cnt}, 32'd5);

    // memory wait at 0x80
    imem_rdy = 1'b1; pcsource = 2'b11; jpc = 32'h80;
    tick();
    check_val("j80_pc", pc, 32'h80);
    bubble = 1'b0; pcsource = 2'b00; imem_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_val("w_pc", pc, 32'h80);
      check_val("w_dinst", dinst, 32'h0);
      check_val("w_dvalid", {31'd0, dvalid}, 32'd0);
      check_val("w_dpc4", dpc4, 32'h84);
      check_val("w_cnt", {16'd0, wait_cnt}, i);
    end
    imem_rdy = 1'b1;
    tick();
    check_val("w_done_dinst", dinst, 32'hA500_0080);
    check_val("w_done_pc", pc, 32'h84);
    check_val("w_done_dvalid", {31'd0, dvalid}, 32'd1);

    // pc+4 wraps at top of address space
    bubble = 1'b1; pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    bubble = 1'b0; pcsource = 2'b00;
    tick();
    check_val("wrap_pc", pc, 32'h0);
    check_val("wrap_dpc4", dpc4, 32'h0);
    check_val("wrap_dinst", dinst, 32'hA5FF_FFFC);

    // 2-bit counter saturation
    s_reset = 1'b0; s_bubble = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("sat_sq", {30'd0, s_squash_cnt}, (i > 3) ? 32'd3 : i);
    end
    check_val("sat_pc", s_pc, 32'h1014);

    // async reset mid-cycle, no clock edge in between
    #2;
    reset = 1'b1; s_reset = 1'b1;
    #1;
    check_val("ar_pc", pc, 32'h0);
    check_val("ar_dinst", dinst, 32'h0);
    check_val("ar_dpc4", dpc4, 32'h0);
    check_val("ar_wait", {16'd0, wait_cnt}, 32'd0);
    check_val("ar_sq", {16'd0, squash_cnt}, 32'd0);
    check_val("ar_s_pc", s_pc, 32'h1000);
    check_val("ar_s_sq", {30'd0, s_squash_cnt}, 32'd0);
    check_val("ar_s_addr", s_imem_addr, 32'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_ctl.md
# pipe_fetch_ctl

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. It holds the PC and drives the instruction-memory address. It selects the next PC from the `pcsource` / `bubble` / `wpcir` controls produced by the decode stage. It registers the fetched instruction into the word whose `op`/`func` fields feed the decode control unit. It also squashes the slot after any control transfer, holds on load-use interlock, inserts NOPs while instruction memory is not ready, and keeps two saturating event counters.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `CNT_W`, default 16: width of each event counter.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `wpcir`  in  1: PC/IR write enable from the interlock. 0 = stall.
- `pcsource`  in  2: next-PC select from decode. 00 = pc+4, 01 = branch target, 10 = register target (jr), 11 = jump target.
- `bubble`  in  1: decode holds j/jal/jr/beq/bne; squash the slot being fetched.
- `bpc`  in  32: branch target.
- `rpc`  in  32: jr target.
- `jpc`  in  32: j/jal target.
- `imem_addr`  out  32: fetch address, equal to `pc`.
- `imem_rdata`  in  32: instruction word, combinational read, valid when `imem_rdy` = 1.
- `imem_rdy`  in  1: memory returns `imem_rdata` this cycle.
- `pc`  out  32: current PC register.
- `dinst`  out  32: IF/ID instruction. Decode takes `op` = [31:26] and `func` = [5:0].
- `dpc4`  out  32: IF/ID copy of pc+4.
- `dvalid`  out  1: IF/ID holds a real fetched instruction (0 = inserted NOP).
- `squash_cnt`  out  `CNT_W`: count of slots squashed by `bubble`.
- `wait_cnt`  out  `CNT_W`: count of NOPs inserted for `imem_rdy` = 0.

## Operation
- `pc4` = `pc` + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- `npc` is selected by `pcsource`: pc4, `bpc`, `rpc`, `jpc`.
- NOP encoding is 32'h0000_0000. Decode treats it as sll $0,$0,0, which is harmless.
- Per-edge priority, first match wins:
  1. `reset` asserted: `pc` = `RESET_PC`; `dinst`, `dpc4`, `dvalid`, `squash_cnt`, `wait_cnt` = 0.
  2. `wpcir` = 0 (stall): `pc`, `dinst`, `dpc4`, `dvalid` and both counters hold. `bubble`, `pcsource` and `imem_rdy` are ignored.
  3. `bubble` = 1: `pc` ← `npc`; `dinst` ← NOP; `dpc4` ← pc4; `dvalid` ← 0; `squash_cnt` += 1. This applies regardless of `imem_rdy`, because the slot is discarded either way. Not-taken branches (`pcsource` = 00) still squash and advance to pc4.
  4. `imem_rdy` = 0: `pc` holds; `dinst` ← NOP; `dvalid` ← 0; `dpc4` ← pc4; `wait_cnt` += 1.
  5. Normal: `pc` ← `npc`; `dinst` ← `imem_rdata`; `dpc4` ← pc4; `dvalid` ← 1.
- Counters saturate at 2^`CNT_W` − 1 and never wrap.
- `pcsource` ≠ 00 with `bubble` = 0 is illegal from decode. The block still follows rule 5 and takes `npc`.

## Timing
- `imem_addr` = `pc` combinationally. `imem_rdata`/`imem_rdy` are sampled at the same edge that updates `pc`.
- Fetch-to-decode latency is 1 cycle: the word sampled at edge N appears on `dinst` after edge N.
- Redirect penalty is exactly one squashed slot: the target is fetched in the cycle after decode shows the control transfer.
- While `reset` is high, all outputs sit at their reset values and `imem_addr` = `RESET_PC`. Reset takes effect asynchronously and aborts any stall or wait.
- Stall lasting k cycles: `pc`/`dinst` are unchanged for k edges, then resume with the rule chosen at the first edge where `wpcir` = 1.
- Memory wait of k cycles: k NOPs enter decode and `pc` is stable across the wait.

## Test plan
- Reset, then `imem_rdy` = 1 fetching 0x20080005, 0x21090001 at 0x0/0x4.
  - After reset release, `imem_addr` = 0.
  - After edge 1: `dinst` = 0x20080005, `dpc4` = 4, `dvalid` = 1, `pc` = 4.
  - After edge 2: `dinst` = 0x21090001, `pc` = 8.
- `pc` = 0x40, `bubble` = 1, `pcsource` = 01, `bpc` = 0x100 → next edge: `pc` = 0x100, `dinst` = 0, `dvalid` = 0, `squash_cnt` = 1. Following edge: `dinst` = word at 0x100.
- Not-taken bne: `pc` = 0x40, `bubble` = 1, `pcsource` = 00 → `pc` = 0x44, `dinst` = 0, `squash_cnt` += 1.
- jr with stall: `wpcir` = 0 for 2 cycles together with `bubble` = 1, `pcsource` = 10, `rpc` = 0x200.
  - During the stall, `pc`, `dinst` and `squash_cnt` hold.
  - At the first edge with `wpcir` = 1: `pc` = 0x200, `dinst` = 0.
- Memory wait: `imem_rdy` = 0 for 3 cycles at `pc` = 0x80 → `pc` stays 0x80, 3 NOPs with `dvalid` = 0, `wait_cnt` = 3. On ready: `dinst` = word at 0x80, `pc` = 0x84.
- `CNT_W` = 2: 5 consecutive squashes → `squash_cnt` reads 1, 2, 3, 3, 3. Assert `reset` mid-cycle → all outputs clear immediately, without waiting for a clock edge.
